// File: rtl/note_recorder_player_pkg.sv
// Shared types and constants for the note record/playback engine.
// Buffer entries are packed as {note, octave, dur} with dur in the low bits.
package note_recorder_player_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REC,
        LOAD,
        PLAY
    } state_t;

    localparam logic [1:0] SPD_1X   = 2'b00;
    localparam logic [1:0] SPD_HALF = 2'b01;
    localparam logic [1:0] SPD_2X   = 2'b10;
    localparam logic [1:0] SPD_4X   = 2'b11;

    localparam int REST    = 0;
    localparam int DUR_LSB = 0;

    function automatic int octLsb(input int durW);
        return durW;
    endfunction

    function automatic int noteLsb(input int durW, input int octW);
        return durW + octW;
    endfunction

endpackage

// File: rtl/note_recorder_player_ram.sv
// Entry store for recorded songs: one write port, registered read port,
// shaped so synthesis can map it onto distributed or block RAM.
module note_buffer_ram #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 14
) (
    input  logic                     i_clk,
    input  logic                     i_wrEn,
    input  logic [$clog2(DEPTH)-1:0] i_wrAddr,
    input  logic [WIDTH-1:0]         i_wrData,
    input  logic [$clog2(DEPTH)-1:0] i_rdAddr,
    output logic [WIDTH-1:0]         o_rdData
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_wrEn) begin
            r_mem[i_wrAddr] <= i_wrData;
        end
        o_rdData <= r_mem[i_rdAddr];
    end

endmodule

// File: rtl/note_recorder_player.sv
// Record/playback engine between key encoder and buzzer: live passthrough,
// run-length capture of held notes, and speed-scaled replay of the buffer.
module note_recorder_player
    import note_recorder_player_pkg::*;
#(
    parameter int DEPTH    = 64,
    parameter int TICK_DIV = 1_000_000,
    parameter int DUR_W    = 8,
    parameter int NOTE_W   = 4,
    parameter int OCT_W    = 2
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_rec_start,
    input  logic                       i_play_start,
    input  logic                       i_stop,
    input  logic [NOTE_W-1:0]          i_note_in,
    input  logic [OCT_W-1:0]           i_octave_in,
    input  logic [1:0]                 i_speed_select,
    output logic [NOTE_W-1:0]          o_note_out,
    output logic [OCT_W-1:0]           o_octave_out,
    output logic                       o_recording,
    output logic                       o_playing,
    output logic                       o_full,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_done
);

    localparam int AW       = $clog2(DEPTH);
    localparam int CW       = $clog2(DEPTH + 1);
    localparam int KW       = NOTE_W + OCT_W;
    localparam int EW       = KW + DUR_W;
    localparam int LW       = DUR_W + 1;
    localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int NOTE_LSB = noteLsb(DUR_W, OCT_W);
    localparam int OCT_LSB  = octLsb(DUR_W);
    localparam logic [DUR_W-1:0] DUR_MAX = '1;

    state_t            r_state, w_nextState;
    logic [TW-1:0]     r_tickCnt;
    logic [CW-1:0]     r_count;
    logic [AW-1:0]     r_wrPtr, r_rdPtr;
    logic              r_full, r_done, r_loadWait;
    logic [KW-1:0]     r_cur, w_live;
    logic [DUR_W-1:0]  r_dur, w_entryDur;
    logic [LW-1:0]     r_playLen, w_loadLen;
    logic [NOTE_W-1:0] r_playNote;
    logic [OCT_W-1:0]  r_playOct;
    logic [EW-1:0]     w_rdData;
    logic              w_tick, w_recCmd, w_recTick, w_extend, w_wrEn;
    logic              w_fillDone, w_lastEntry, w_enter;

    assign w_live      = {i_note_in, i_octave_in};
    assign w_tick      = (r_tickCnt == TW'(TICK_DIV - 1));
    assign w_recCmd    = i_rec_start && !i_stop;
    assign w_recTick   = (r_state == REC) && w_tick && !i_stop && !i_rec_start;
    assign w_extend    = (w_live == r_cur) && (r_dur != DUR_MAX);
    assign w_wrEn      = (r_state == REC) && (r_dur != '0) &&
                         (i_stop || (w_recTick && !w_extend));
    assign w_fillDone  = w_wrEn && (r_count == CW'(DEPTH - 1));
    assign w_lastEntry = (CW'(r_rdPtr) + CW'(1)) == r_count;
    assign w_enter     = (w_nextState != r_state) || w_recCmd;
    assign w_entryDur  = w_rdData[DUR_LSB +: DUR_W];

    note_buffer_ram #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_ram (
        .i_clk    (i_clk),
        .i_wrEn   (w_wrEn),
        .i_wrAddr (r_wrPtr),
        .i_wrData ({r_cur, r_dur}),
        .i_rdAddr (r_rdPtr),
        .o_rdData (w_rdData)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        if (i_stop) begin
            w_nextState = IDLE;
        end else if (i_rec_start) begin
            w_nextState = REC;
        end else begin
            case (r_state)
                IDLE:    if (i_play_start && r_count != '0) w_nextState = LOAD;
                REC:     if (w_fillDone) w_nextState = IDLE;
                LOAD:    if (!r_loadWait) w_nextState = PLAY;
                PLAY:    if (w_tick && r_playLen == LW'(1))
                             w_nextState = w_lastEntry ? IDLE : LOAD;
                default: w_nextState = IDLE;
            endcase
        end
    end

    always_comb begin
        o_recording  = (r_state == REC);
        o_playing    = (r_state == LOAD) || (r_state == PLAY);
        o_note_out   = i_note_in;
        o_octave_out = i_octave_in;
        if ((r_state == LOAD) || (r_state == PLAY)) begin
            o_note_out   = r_playNote;
            o_octave_out = r_playOct;
        end
    end

    // Fast speeds never shrink an entry below one tick.
    always_comb begin
        w_loadLen = {1'b0, w_entryDur};
        case (i_speed_select)
            SPD_1X:   w_loadLen = {1'b0, w_entryDur};
            SPD_HALF: w_loadLen = {w_entryDur, 1'b0};
            SPD_2X:   w_loadLen = LW'(w_entryDur >> 1);
            SPD_4X:   w_loadLen = LW'(w_entryDur >> 2);
        endcase
        if (w_loadLen == '0) begin
            w_loadLen = LW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset || w_enter || w_tick) begin
            r_tickCnt <= '0;
        end else begin
            r_tickCnt <= r_tickCnt + TW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count    <= '0;
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_full     <= 1'b0;
            r_done     <= 1'b0;
            r_cur      <= '0;
            r_dur      <= '0;
            r_loadWait <= 1'b0;
            r_playLen  <= '0;
            r_playNote <= '0;
            r_playOct  <= '0;
        end else begin
            r_done <= 1'b0;

            if (w_recCmd) begin
                r_count <= '0;
                r_wrPtr <= '0;
                r_full  <= 1'b0;
            end else if (w_wrEn) begin
                r_count <= r_count + CW'(1);
                r_wrPtr <= r_wrPtr + AW'(1);
                if (w_fillDone) r_full <= 1'b1;
            end

            // A change of key (or a saturated run) closes the entry and opens a new one.
            if (w_recCmd) begin
                r_cur <= w_live;
                r_dur <= '0;
            end else if (w_recTick) begin
                if (w_extend) begin
                    r_dur <= r_dur + DUR_W'(1);
                end else begin
                    r_cur <= w_live;
                    r_dur <= DUR_W'(1);
                end
            end

            if (i_stop || w_recCmd) begin
                r_rdPtr    <= '0;
                r_loadWait <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (i_play_start) begin
                            if (r_count == '0) begin
                                r_done <= 1'b1;
                            end else begin
                                r_rdPtr    <= '0;
                                r_loadWait <= 1'b1;
                                r_playNote <= NOTE_W'(REST);
                                r_playOct  <= '0;
                            end
                        end
                    end
                    LOAD: begin
                        if (r_loadWait) begin
                            r_loadWait <= 1'b0;
                        end else begin
                            r_playNote <= w_rdData[NOTE_LSB +: NOTE_W];
                            r_playOct  <= w_rdData[OCT_LSB +: OCT_W];
                            r_playLen  <= w_loadLen;
                        end
                    end
                    PLAY: begin
                        if (w_tick) begin
                            r_playLen <= r_playLen - LW'(1);
                            if (r_playLen == LW'(1)) begin
                                if (w_lastEntry) begin
                                    r_rdPtr <= '0;
                                    r_done  <= 1'b1;
                                end else begin
                                    r_rdPtr    <= r_rdPtr + AW'(1);
                                    r_loadWait <= 1'b1;
                                end
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_count = r_count;
    assign o_full  = r_full;
    assign o_done  = r_done;

endmodule

// File: doc/note_recorder_player.md
Name: note_recorder_player

Overview:
- Parametrised record/playback engine for the piano datapath. It sits between the key encoder and the buzzer.
- Free mode: passes the live note/octave straight through.
- Record mode: captures run-length-encoded {note, octave, duration} entries into an internal buffer.
- Play mode: replays the buffer at a selectable speed. This generalises the fixed-song auto mode to user-recorded songs of parametrised depth and timing resolution.

Parameters:
- DEPTH, 64, number of buffer entries (power of two, ≥4)
- TICK_DIV, 1_000_000, clk cycles per duration tick (10 ms at 100 MHz)
- DUR_W, 8, duration field width in ticks (max entry length 2^DUR_W-1)
- NOTE_W, 4, note code width (0 = rest)
- OCT_W, 2, octave code width

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rec_start  in  1  single-cycle pulse: clear buffer, begin recording
- play_start  in  1  single-cycle pulse: begin playback from entry 0
- stop  in  1  single-cycle pulse: end record/play
- note_in  in  NOTE_W  live note code
- octave_in  in  OCT_W  live octave
- speed_select  in  2  playback speed
- note_out  out  NOTE_W  note to buzzer
- octave_out  out  OCT_W  octave to buzzer
- recording  out  1  high in REC
- playing  out  1  high in LOAD/PLAY
- full  out  1  buffer full (sticky until rec_start or reset)
- count  out  $clog2(DEPTH+1)  valid entries stored
- done  out  1  one-cycle pulse when playback ends or is refused

Behaviour:
- Reset: state = IDLE; count, wr_ptr, rd_ptr, tick counter, dur counters = 0; full = 0; done = 0; recording = playing = 0. Buffer contents are don't-care.
- Tick generator: free-running counter 0..TICK_DIV-1; tick = 1 for one cycle at terminal count. The counter restarts at 0 on every state entry.
- Command priority within a cycle: reset > stop > rec_start > play_start.
- IDLE:
  - note_out/octave_out = note_in/octave_in (combinational passthrough).
  - rec_start → REC.
  - play_start with count>0 → LOAD.
  - play_start with count==0 → stay IDLE, done pulse next cycle.
- REC:
  - Outputs pass through. rec_start in the same cycle as entry clears count/wr_ptr/full.
  - cur = {note_in, octave_in} latched on entry; dur = 0.
  - On each tick, if live input equals cur and dur < 2^DUR_W-1: dur++.
  - On each tick otherwise: write {cur, dur} at wr_ptr if dur>0; wr_ptr++; count++; cur = live input; dur = 1.
  - When count reaches DEPTH: full = 1, → IDLE, no further writes.
  - stop: flush the pending entry if dur>0 and count<DEPTH, then → IDLE.
  - play_start is ignored in REC.
- LOAD:
  - Synchronous buffer read of rd_ptr, 1-cycle latency.
  - Next cycle latch entry; compute play_len, then → PLAY.
  - playing = 1; outputs hold the previous entry (rest on the first entry).
- play_len by speed_select:
  - 00: dur
  - 01: dur<<1 (half speed)
  - 10: max(dur>>1, 1)
  - 11: max(dur>>2, 1)
  - Width is DUR_W+1, no overflow.
- PLAY:
  - note_out/octave_out = latched entry.
  - Decrement play_len on tick. At 0: rd_ptr++.
  - If rd_ptr == count-1 at that point: → IDLE, done pulse, rd_ptr = 0. Else → LOAD.
  - speed_select is sampled only in LOAD. Changes take effect at the next entry.
  - stop → IDLE immediately, rd_ptr = 0, no done pulse. rec_start aborts playback and → REC.
- Stored note code 0 plays as silence; octave is passed unchanged.
- count, full and buffer contents survive stop and play. Only rec_start and reset clear count/full.

Decomposition:
- Shared package holds:
  - state enum {IDLE, REC, LOAD, PLAY}
  - speed encodings SPD_1X=00, SPD_HALF=01, SPD_2X=10, SPD_4X=11
  - REST note code 0
  - entry field offsets {note, octave, dur} for a DUR_W+NOTE_W+OCT_W word
- Sub-module: note_buffer_ram. Single-port write, synchronous-read RAM of DEPTH × entry width, inferable as distributed/block RAM.
- Tick generator and FSM stay in the top.

Test Plan (TICK_DIV=4, DEPTH=4, DUR_W=3):
- Reset mid-PLAY → next cycle state IDLE, count=0, playing=0, note_out follows note_in.
- Record: rec_start, note 3/oct 1 for 3 ticks, note 5/oct 2 for 2 ticks, stop → count=2, entries {3,1,3},{5,2,2}; recording falls the cycle after stop.
- Play at speed 00 → note_out=3 for 3 ticks, then 5 for 2 ticks; done pulses once; playing falls; note_out returns to passthrough.
- Same buffer at speed 01 → durations 6 and 4 ticks. At speed 11 → 1 and 1 tick (floor clamp).
- Record 5 distinct notes → full=1 after the 4th write, state IDLE, count=4, 5th note not stored.
- Hold one note for 10 ticks → entries dur=7 then dur=3 (saturation split).
- play_start with count=0 → done pulse, playing stays 0.
- stop+rec_start in the same cycle → stop wins, IDLE.
